// File: rtl/string_tape_accumulator_pkg.sv
// Shared types and constants for the string tape accumulator.
package string_tape_accumulator_pkg;

    localparam int TAPE_DEPTH_DEFAULT = 256;
    localparam int TAPE_INDEX_W       = $clog2(TAPE_DEPTH_DEFAULT);

    typedef logic [7:0]              UTF8_Char;
    typedef logic [TAPE_INDEX_W-1:0] TapeIndex;

endpackage

// File: rtl/string_tape_accumulator.sv
// String tape accumulator: packs a stream of zero-terminated byte strings into
// a flop-array tape, each string stored as a 4-byte little-endian length,
// the payload, and a 0x00 terminator. Input is ignored once the tape is full.
module string_tape_accumulator
    import string_tape_accumulator_pkg::*;
#(
    parameter int TAPE_DEPTH = TAPE_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  UTF8_Char                      nextStringByte,
    output logic [$clog2(TAPE_DEPTH)-1:0] curIndex,
    output logic [7:0]                    tape [TAPE_DEPTH]
);

    localparam int AW = $clog2(TAPE_DEPTH);
    localparam logic [AW:0] DEPTH_PTR = (AW+1)'(TAPE_DEPTH);

    // Start pointer is one bit wider so that "tape full" (== TAPE_DEPTH) is representable.
    logic [AW:0]  start_reg, start_next;
    logic [31:0]  len_reg, len_next;

    // Address arithmetic is done wide so S+4+len can never wrap.
    logic [33:0]  start_wide;
    logic [33:0]  wr_addr_wide;
    logic [33:0]  term_next_wide;
    logic [AW:0]  wr_ptr;
    logic         active;
    logic         is_term;
    logic         payload_fits;

    logic [TAPE_DEPTH-1:0] byte_we;
    logic [7:0]            byte_wd [TAPE_DEPTH];

    assign start_wide     = 34'(start_reg);
    assign wr_addr_wide   = start_wide + 34'd4 + 34'(len_reg);
    assign term_next_wide = wr_addr_wide + 34'd1;
    assign wr_ptr         = (wr_addr_wide >= 34'(TAPE_DEPTH)) ? DEPTH_PTR : wr_addr_wide[AW:0];
    assign payload_fits   = (wr_ptr != DEPTH_PTR);
    assign is_term        = (nextStringByte == 8'h00);
    // Once the start pointer has saturated, the tape is frozen until reset.
    assign active         = enable && (start_reg != DEPTH_PTR);

    assign curIndex = (start_reg == DEPTH_PTR) ? AW'(TAPE_DEPTH - 1) : start_reg[AW-1:0];

    // Next-state for the string start pointer and payload length counter.
    always_comb begin
        start_next = start_reg;
        len_next   = len_reg;
        if (active) begin
            if (is_term) begin
                start_next = (term_next_wide >= 34'(TAPE_DEPTH)) ? DEPTH_PTR : term_next_wide[AW:0];
                len_next   = 32'd0;
            end else if (payload_fits) begin
                // Dropped bytes are not counted, so the length field matches what is stored.
                len_next = len_reg + 32'd1;
            end
        end
    end

    // Pointer and length registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_reg <= '0;
            len_reg   <= '0;
        end else begin
            start_reg <= start_next;
            len_reg   <= len_next;
        end
    end

    // Per-byte write decode: a byte is written either as the current data/terminator
    // target or, on a terminator, as one of the four length-field bytes at S..S+3.
    generate
        for (genvar gi = 0; gi < TAPE_DEPTH; gi++) begin : g_byte
            localparam logic [33:0] IDX = 34'(gi);
            logic       is_data_slot;
            logic       is_len_slot;
            logic [1:0] len_sel;

            assign is_data_slot = (wr_addr_wide == IDX);
            assign is_len_slot  = is_term && (IDX >= start_wide) && (IDX < start_wide + 34'd4);
            assign len_sel      = 2'(IDX - start_wide);
            assign byte_we[gi]  = active && (is_data_slot || is_len_slot);
            assign byte_wd[gi]  = is_data_slot ? nextStringByte : len_reg[{len_sel, 3'b000} +: 8];
        end
    endgenerate

    // Tape storage: cleared by reset, otherwise updated per byte enable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < TAPE_DEPTH; i++) begin
            if (rst) begin
                tape[i] <= 8'h00;
            end else if (byte_we[i]) begin
                tape[i] <= byte_wd[i];
            end
        end
    end

endmodule

// File: tb/tb_string_tape_accumulator.sv
// Directed, scoreboard-driven bench for string_tape_accumulator (depth 256 and depth 16).
module tb_string_tape_accumulator;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, en_a = 1'b0;
    logic [7:0] byte_a = 8'h00;
    logic [7:0] cur_a;
    logic [7:0] tape_a [256];

    logic       rst_b = 1'b0, en_b = 1'b0;
    logic [7:0] byte_b = 8'h00;
    logic [3:0] cur_b;
    logic [7:0] tape_b [16];

    int passed = 0;
    int total  = 0;

    typedef struct {
        string tag;
        int    sel;   // 0: depth-256 instance, 1: depth-16 instance
        int    idx;   // -1 selects curIndex
        int    exp;
    } chk_t;

    chk_t sb [$];

    // Expected tape image of "apple" followed by "pie".
    int img [18] = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h61, 8'h70, 8'h70, 8'h6C, 8'h65, 8'h00,
                     8'h03, 8'h00, 8'h00, 8'h00, 8'h70, 8'h69, 8'h65, 8'h00};

    always #5 clk = ~clk;

    string_tape_accumulator #(.TAPE_DEPTH(256)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .nextStringByte(byte_a),
        .curIndex(cur_a), .tape(tape_a)
    );

    string_tape_accumulator #(.TAPE_DEPTH(16)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .nextStringByte(byte_b),
        .curIndex(cur_b), .tape(tape_b)
    );

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic void push(string tag, int sel, int idx, int exp);
        chk_t c;
        c.tag = tag; c.sel = sel; c.idx = idx; c.exp = exp;
        sb.push_back(c);
    endfunction

    function automatic int observe(int sel, int idx);
        if (sel == 0) return (idx < 0) ? int'(cur_a) : int'(tape_a[idx]);
        return (idx < 0) ? int'(cur_b) : int'(tape_b[idx]);
    endfunction

    function automatic void push_zero(string tag, int sel, int from, int to);
        for (int i = from; i <= to; i++) push(tag, sel, i, 0);
    endfunction

    function automatic void push_apple_pie(string tag);
        for (int i = 0; i < 18; i++) push(tag, 0, i, img[i]);
        push_zero(tag, 0, 18, 255);
        push({tag, "_cur"}, 0, -1, 18);
    endfunction

    // Compare every queued expectation against the DUT; called away from the active edge.
    task automatic drain();
        chk_t c;
        int obs;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            obs = observe(c.sel, c.idx);
            total = total + 1;
            assert (obs === c.exp) passed = passed + 1;
            else $error("FAIL %s idx=%0d observed=%02h expected=%02h", c.tag, c.idx, obs, c.exp);
        end
    endtask

    task automatic feed(int sel, logic [7:0] b);
        @(negedge clk);
        if (sel == 0) begin en_a = 1'b1; byte_a = b; end
        else          begin en_b = 1'b1; byte_b = b; end
    endtask

    task automatic feed_str(int sel, string s, bit term);
        for (int i = 0; i < s.len(); i++) feed(sel, s[i]);
        if (term) feed(sel, 8'h00);
    endtask

    // Lower enable at the next falling edge, after the last byte has been captured.
    task automatic idle();
        @(negedge clk);
        en_a = 1'b0; en_b = 1'b0;
    endtask

    // Reset with enable held high and a non-zero byte, so reset priority is exercised.
    task automatic do_reset(int sel, int cycles);
        @(negedge clk);
        if (sel == 0) begin rst_a = 1'b1; en_a = 1'b1; byte_a = 8'h71; end
        else          begin rst_b = 1'b1; en_b = 1'b1; byte_b = 8'h71; end
        repeat (cycles) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    endtask

    initial begin
        // Power-on reset of both instances.
        do_reset(0, 2);
        do_reset(1, 2);
        push("rst_cur", 0, -1, 0);
        push_zero("rst_tape", 0, 0, 255);
        push("rst16_cur", 1, -1, 0);
        push_zero("rst16_tape", 1, 0, 15);
        drain();

        // One-cycle write latency; length field untouched mid-string.
        feed(0, 8'h61);
        idle();
        push("lat_byte", 0, 4, 8'h61);
        push("lat_next", 0, 5, 8'h00);
        push("lat_len", 0, 0, 8'h00);
        push("lat_cur", 0, -1, 0);
        drain();

        feed_str(0, "pple", 1'b1);
        idle();
        for (int i = 0; i < 10; i++) push("apple", 0, i, img[i]);
        push("apple_cur", 0, -1, 10);
        drain();

        feed_str(0, "pie", 1'b1);
        idle();
        push_apple_pie("pie");
        drain();

        // Enable low: nothing may change while the input byte toggles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            byte_a = 8'($urandom_range(1, 255));
        end
        push_apple_pie("hold");
        drain();

        // Reset mid-string, then rerun; the result must match the power-on run.
        do_reset(0, 2);
        feed_str(0, "app", 1'b0);
        idle();
        push("part_byte", 0, 6, 8'h70);
        push("part_cur", 0, -1, 0);
        drain();
        do_reset(0, 4);
        push("midrst_cur", 0, -1, 0);
        push_zero("midrst_tape", 0, 0, 255);
        drain();
        feed_str(0, "apple", 1'b1);
        feed_str(0, "pie", 1'b1);
        idle();
        push_apple_pie("rerun");
        drain();

        // Empty string followed by a one-byte string.
        do_reset(0, 2);
        feed(0, 8'h00);
        idle();
        push_zero("empty", 0, 0, 4);
        push("empty_cur", 0, -1, 5);
        drain();
        feed_str(0, "x", 1'b1);
        idle();
        push("x_len0", 0, 5, 8'h01);
        push_zero("x_len", 0, 6, 8);
        push("x_byte", 0, 9, 8'h78);
        push("x_term", 0, 10, 8'h00);
        push("x_cur", 0, -1, 11);
        drain();

        // Overflow on the 16-byte tape: 20 payload bytes, only 12 fit.
        for (int i = 0; i < 20; i++) feed(1, 8'h7A);
        idle();
        push("ovf_pre_len", 1, 0, 8'h00);
        push("ovf_pre_cur", 1, -1, 0);
        drain();
        feed(1, 8'h00);
        idle();
        push("ovf_len0", 1, 0, 8'h0C);
        push_zero("ovf_len", 1, 1, 3);
        for (int i = 4; i < 16; i++) push("ovf_z", 1, i, 8'h7A);
        push("ovf_cur", 1, -1, 15);
        drain();
        feed_str(1, "ab", 1'b1);
        feed(1, 8'h00);
        idle();
        push("frozen_len0", 1, 0, 8'h0C);
        push_zero("frozen_len", 1, 1, 3);
        for (int i = 4; i < 16; i++) push("frozen_z", 1, i, 8'h7A);
        push("frozen_cur", 1, -1, 15);
        drain();

        // Reset clears saturation; the next string starts at offset 0 again.
        do_reset(1, 2);
        feed_str(1, "hi", 1'b1);
        idle();
        push("post_len0", 1, 0, 8'h02);
        push_zero("post_len", 1, 1, 3);
        push("post_h", 1, 4, 8'h68);
        push("post_i", 1, 5, 8'h69);
        push_zero("post_rest", 1, 6, 15);
        push("post_cur", 1, -1, 7);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
